// File: rtl/bitty_sequencer.sv
// Instruction sequencer for bitty_core: fetches from synchronous program memory,
// issues each instruction with a one-cycle run pulse and waits for done.
module bitty_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rd_data,
  output logic              run,
  output logic [15:0]       instruction,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_HALT, S_ERROR
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  end_reg;
  logic [TMR_W-1:0]   timer;

  assign mem_addr = pc;

  // Next-state decode; done beats timeout when both land in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_HALT, S_ERROR: if (start) state_n = S_FETCH;
      S_FETCH: state_n = S_LOAD;
      S_LOAD:  state_n = (mem_rd_data == HALT_INSTR) ? S_HALT : S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (done)
          state_n = (pc == end_reg) ? S_HALT : S_FETCH;
        else if (timer == TMR_W'(TIMEOUT - 1))
          state_n = S_ERROR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and status flags registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      end_reg     <= '0;
      instruction <= '0;
      timer       <= '0;
      instr_count <= '0;
      run         <= 1'b0;
      mem_rd_en   <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state     <= state_n;
      mem_rd_en <= (state_n == S_FETCH);
      run       <= (state_n == S_ISSUE);
      busy      <= state_n inside {S_FETCH, S_LOAD, S_ISSUE, S_WAIT};
      halted    <= (state_n == S_HALT);
      error     <= (state_n == S_ERROR);

      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            pc          <= start_addr;
            end_reg     <= end_addr;
            instr_count <= '0;
          end
        end
        S_LOAD: begin
          if (mem_rd_data != HALT_INSTR) instruction <= mem_rd_data;
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (done) begin
            if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
            if (pc != end_reg) pc <= pc + ADDR_W'(1);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed, table-driven bench for bitty_sequencer with a memory and core model.
module tb_bitty_sequencer;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rd_data;
  logic              run;
  logic [15:0]       instruction;
  logic              done;
  logic              busy;
  logic              halted;
  logic              error;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  instr_count;

  bitty_sequencer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .HALT_INSTR(16'hFFFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .run(run), .instruction(instruction),
    .done(done), .busy(busy), .halted(halted), .error(error), .pc(pc),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Program memory: content A5xx except a HALT opcode at address 5.
  logic [15:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Core model: done high on WAIT cycle number 'delay' (0 = never).
  int delay = 2;
  int cd;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cd   <= 0;
      done <= 1'b0;
    end else if (run && delay > 0) begin
      cd   <= delay - 1;
      done <= (delay == 1);
    end else if (cd > 0) begin
      cd   <= cd - 1;
      done <= (cd == 1);
    end else begin
      done <= 1'b0;
    end
  end

  // Observation logs sampled mid-cycle.
  int          cyc = 0;
  logic [15:0] run_q[$];
  int          run_cyc[$];
  logic [7:0]  fetch_q[$];
  logic        prev_run = 1'b0;
  int          consec_err = 0;
  always @(negedge clk) begin
    cyc++;
    if (run) begin
      run_q.push_back(instruction);
      run_cyc.push_back(cyc);
    end
    if (mem_rd_en) fetch_q.push_back(mem_addr);
    if (run && prev_run) consec_err++;
    prev_run = run;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] sa, input logic [7:0] ea);
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    end_addr   = ea;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  sa;
    logic [7:0]  ea;
    int          dly;
    int          cnt;
    logic [7:0]  pc;
    logic        halted;
    logic        err;
    int          runs;
    logic [15:0] first;
    logic [15:0] last;
    int          fetches;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int rb, fb, gap_bad;
    vec_t v;

    vecs[0] = '{8'h00, 8'h03, 2,  4, 8'h03, 1'b1, 1'b0, 4, 16'hA500, 16'hA503, 4};
    vecs[1] = '{8'h04, 8'h09, 2,  1, 8'h05, 1'b1, 1'b0, 1, 16'hA504, 16'hA504, 2};
    vecs[2] = '{8'hFE, 8'h01, 3,  4, 8'h01, 1'b1, 1'b0, 4, 16'hA5FE, 16'hA501, 4};
    vecs[3] = '{8'h10, 8'h10, 1,  1, 8'h10, 1'b1, 1'b0, 1, 16'hA510, 16'hA510, 1};
    vecs[4] = '{8'h20, 8'h22, 32, 3, 8'h22, 1'b1, 1'b0, 3, 16'hA520, 16'hA522, 3};
    vecs[5] = '{8'h30, 8'h31, 0,  0, 8'h30, 1'b0, 1'b1, 1, 16'hA530, 16'hA530, 1};

    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
    mem[5] = 16'hFFFF;

    reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_instr", 32'(instruction), 0);
    reset = 1'b0;
    @(negedge clk);

    // Start-to-run latency: FETCH, LOAD, then run.
    delay = 2;
    do_start(8'h00, 8'h03);
    chk("lat_fetch_en", 32'(mem_rd_en), 1);
    chk("lat_fetch_addr", 32'(mem_addr), 0);
    chk("lat_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_load_run", 32'(run), 0);
    @(negedge clk);
    chk("lat_issue_run", 32'(run), 1);
    chk("lat_issue_instr", 32'(instruction), 32'h0000A500);
    wait_idle(ok);
    chk("lat_idle", 32'(ok), 1);

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      delay = v.dly;
      rb = run_q.size();
      fb = fetch_q.size();
      do_start(v.sa, v.ea);
      wait_idle(ok);
      chk($sformatf("v%0d_done", k), 32'(ok), 1);
      chk($sformatf("v%0d_count", k), 32'(instr_count), 32'(v.cnt));
      chk($sformatf("v%0d_pc", k), 32'(pc), 32'(v.pc));
      chk($sformatf("v%0d_halted", k), 32'(halted), 32'(v.halted));
      chk($sformatf("v%0d_error", k), 32'(error), 32'(v.err));
      chk($sformatf("v%0d_runs", k), 32'(run_q.size() - rb), 32'(v.runs));
      chk($sformatf("v%0d_fetches", k), 32'(fetch_q.size() - fb), 32'(v.fetches));
      if (run_q.size() > rb) begin
        chk($sformatf("v%0d_first", k), 32'(run_q[rb]), 32'(v.first));
        chk($sformatf("v%0d_last", k), 32'(run_q[run_q.size() - 1]), 32'(v.last));
        chk($sformatf("v%0d_held", k), 32'(instruction), 32'(v.last));
      end
      for (int j = 0; j < v.fetches && fb + j < fetch_q.size(); j++)
        chk($sformatf("v%0d_faddr%0d", k, j), 32'(fetch_q[fb + j]), 32'(8'(v.sa + 8'(j))));
      gap_bad = 0;
      for (int j = rb + 1; j < run_q.size(); j++)
        if (run_cyc[j] - run_cyc[j - 1] != v.dly + 3) gap_bad++;
      chk($sformatf("v%0d_gap", k), 32'(gap_bad), 0);
    end

    // Timeout exactness: error 32 cycles after WAIT entry, not earlier.
    delay = 0;
    do_start(8'h40, 8'h40);
    @(negedge clk);
    @(negedge clk);
    chk("to_issue", 32'(run), 1);
    repeat (TIMEOUT) @(negedge clk);
    chk("to_last_wait_err", 32'(error), 0);
    chk("to_last_wait_busy", 32'(busy), 1);
    @(negedge clk);
    chk("to_error", 32'(error), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_pc", 32'(pc), 32'h40);

    // Reset during WAIT of the second instruction.
    delay = 5;
    rb = run_q.size();
    do_start(8'h00, 8'h03);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (run_q.size() >= rb + 2) ok = 1'b1;
    end
    chk("rw_second_run", 32'(ok), 1);
    @(negedge clk);
    chk("rw_pre_pc", 32'(pc), 1);
    chk("rw_pre_count", 32'(instr_count), 1);
    reset = 1'b1;
    #1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_run", 32'(run), 0);
    chk("rw_pc", 32'(pc), 0);
    chk("rw_count", 32'(instr_count), 0);
    @(negedge clk);
    reset = 1'b0;
    delay = 2;
    do_start(8'h00, 8'h01);
    wait_idle(ok);
    chk("rw_restart_idle", 32'(ok), 1);
    chk("rw_restart_count", 32'(instr_count), 2);
    chk("rw_restart_halted", 32'(halted), 1);

    // start while busy is ignored.
    rb = run_q.size();
    do_start(8'h00, 8'h03);
    repeat (3) @(negedge clk);
    start = 1'b1; start_addr = 8'h50; end_addr = 8'h50;
    @(negedge clk);
    start = 1'b0;
    wait_idle(ok);
    chk("sb_idle", 32'(ok), 1);
    chk("sb_count", 32'(instr_count), 4);
    chk("sb_pc", 32'(pc), 3);
    chk("sb_runs", 32'(run_q.size() - rb), 4);

    // Restart from HALT with a new program.
    do_start(8'h60, 8'h60);
    chk("hr_count_clr", 32'(instr_count), 0);
    chk("hr_halted", 32'(halted), 0);
    @(negedge clk);
    @(negedge clk);
    chk("hr_run", 32'(run), 1);
    chk("hr_instr", 32'(instruction), 32'h0000A560);
    wait_idle(ok);
    chk("hr_final_count", 32'(instr_count), 1);

    chk("run_not_consecutive", 32'(consec_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitty_sequencer.md
Name: bitty_sequencer

Overview:
- Instruction sequencer for bitty_core.
- Fetches 16-bit instructions from a synchronous-read program memory, starting at a programmable start address.
- Issues each instruction to the core with a one-cycle run pulse, holds it stable, and waits for the core's done.
- Advances the PC until the end address or a HALT opcode; reports busy/halted/error status and an executed-instruction count. Sits between program memory and bitty_core.

Parameters:
ADDR_W, 8, program memory address width; PC wraps modulo 2^ADDR_W
CNT_W, 16, width of executed-instruction counter
HALT_INSTR, 16'hFFFF, opcode that stops sequencing; never issued to the core
TIMEOUT, 32, max WAIT cycles allowed for done before error (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin program; sampled only in IDLE, HALT, ERROR
start_addr  input  ADDR_W  first PC value, captured with start
end_addr  input  ADDR_W  last PC executed (inclusive), captured with start
mem_addr  output  ADDR_W  program memory address (= pc)
mem_rd_en  output  1  memory read strobe; data valid on mem_rd_data next cycle
mem_rd_data  input  16  program memory read data
run  output  1  one-cycle pulse to bitty_core
instruction  output  16  instruction to bitty_core; stable from ISSUE through WAIT
done  input  1  bitty_core completion
busy  output  1  high in FETCH, LOAD, ISSUE, WAIT
halted  output  1  high in HALT
error  output  1  high in ERROR
pc  output  ADDR_W  current program counter
instr_count  output  CNT_W  instructions completed since last start

Behaviour:
- Reset (async, immediate): state=IDLE; pc, end register, instruction, timer, instr_count = 0; run, mem_rd_en, busy, halted, error = 0.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, HALT, ERROR. Outputs are registered or decoded from state only; no combinational path from done/start to run.
- IDLE/HALT/ERROR + start=1: pc<=start_addr, end_reg<=end_addr, instr_count<=0, ->FETCH. start=0: remain.
- start outside IDLE/HALT/ERROR: ignored.
- FETCH (1 cycle): mem_rd_en=1, mem_addr=pc; ->LOAD.
- LOAD (1 cycle): if mem_rd_data==HALT_INSTR ->HALT (instruction unchanged, not counted). Else instruction<=mem_rd_data ->ISSUE.
- ISSUE (1 cycle): run=1; timer<=0; ->WAIT. done is ignored in ISSUE.
- WAIT, done=1:
  - instr_count<=instr_count+1, saturating at all-ones.
  - if pc==end_reg ->HALT (pc unchanged); else pc<=pc+1 (wraps to 0 from max) ->FETCH.
- WAIT, done=0: timer<=timer+1; if timer==TIMEOUT-1 ->ERROR.
  - done is therefore accepted on WAIT cycles 1..TIMEOUT.
  - done and timeout in the same cycle: done wins.
- Latency: start sampled at edge N -> run high in cycle N+3; done sampled at edge M -> next run at M+3 (FETCH, LOAD, ISSUE).
- run is never high in two consecutive cycles.
- instruction holds its last value in all states except LOAD capture.
- HALT/ERROR: pc, instruction, instr_count frozen and observable.
- start_addr==end_addr: exactly one instruction executed.
- start_addr>end_addr: PC wraps through max to end_addr.
- Reset in any state (including WAIT with run pending): returns to IDLE immediately; the core is reset by the same reset.

Test Plan:
- Mem[0..3]=A,B,C,D; start_addr=0, end_addr=3; core returns done 2 cycles after run -> 4 run pulses carrying A,B,C,D in order; halted=1, instr_count=4, pc=3.
- Mem[5]=16'hFFFF, start_addr=4, end_addr=9 -> one run (Mem[4]); then halted=1, instr_count=1, pc=5, no second run.
- done never asserted after first run -> error=1 exactly TIMEOUT(32) cycles after WAIT entry; done on WAIT cycle 32 -> no error, sequencing continues.
- ADDR_W=8, start_addr=8'hFE, end_addr=8'h01 -> fetch addresses FE, FF, 00, 01; instr_count=4.
- Assert reset during WAIT of the 2nd instruction -> same cycle busy=0, run=0, pc=0, instr_count=0; subsequent start restarts cleanly.
- start pulsed while busy -> ignored; start in HALT with new addresses -> instr_count cleared, run 3 cycles later with the new program.
